// File: rtl/fifo_drain_packer.sv
// rtl/fifo_drain_packer.sv - byte FIFO read-side controller packing entries into words
// Pops one entry per IDLE/RD/CAP pass, packs LSB lane first, hands words out over valid/ready.
module fifo_drain_packer #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [DATA_W-1:0]       fifo_data,
  output logic                    enable_rd,
  input  logic                    flush,
  output logic [DATA_W*BYTES-1:0] word_out,
  output logic [$clog2(BYTES):0]  word_bytes,
  output logic                    word_valid,
  input  logic                    word_ready
);

  localparam int               CNT_W = $clog2(BYTES) + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;

  // A pending flush outranks a new pop so a partial word never waits behind fresh data.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (cnt == FULL) begin
          next_state = OUT;
        end else if (flush && (cnt != '0)) begin
          next_state = OUT;
        end else if (!fifo_empty) begin
          next_state = RD;
        end
      end
      RD: begin
        next_state = CAP;
      end
      CAP: begin
        capture    = 1'b1;
        next_state = IDLE;
      end
      OUT: begin
        if (word_ready) begin
          accept     = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from next_state so they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      enable_rd  <= 1'b0;
      word_out   <= '0;
      word_bytes <= '0;
      word_valid <= 1'b0;
    end else begin
      state      <= next_state;
      enable_rd  <= (next_state == RD);
      word_valid <= (next_state == OUT);

      if (capture) begin
        for (int k = 0; k < BYTES; k++) begin
          if (cnt == CNT_W'(k)) begin
            word_out[k*DATA_W +: DATA_W] <= fifo_data;
          end
        end
        cnt <= cnt + CNT_W'(1);
      end

      if (accept) begin
        word_out   <= '0;
        word_bytes <= '0;
        cnt        <= '0;
      end else if (next_state == OUT) begin
        word_bytes <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// tb/tb_fifo_drain_packer.sv - scoreboard bench for fifo_drain_packer
module tb_fifo_drain_packer;

  localparam int DATA_W = 8;
  localparam int BYTES  = 4;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        enable_rd;
  logic        flush;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  n;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pend[$];

  int nvec;
  int nerr;
  int ready_mode;
  int empty_mode;
  int en_cnt;
  int valid_cyc;

  fifo_drain_packer #(.DATA_W(DATA_W), .BYTES(BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .enable_rd  (enable_rd),
    .flush      (flush),
    .word_out   (word_out),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference packing: every BYTES accepted entries form one word, lane k = k-th entry.
  task automatic push_expected();
    exp_t e;
    e.w = '0;
    for (int k = 0; k < pend.size(); k++) e.w = e.w | (32'(pend[k]) << (8 * k));
    e.n = 3'(pend.size());
    exp_q.push_back(e);
    pend.delete();
  endtask

  task automatic add_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    pend.push_back(b);
    if (pend.size() == BYTES) push_expected();
  endtask

  task automatic drain_fifo();
    int t;
    t = 0;
    while (fifo_q.size() != 0 && t < 1000) begin
      tick();
      t++;
    end
    chk("drain_timeout", 32'(fifo_q.size()), 0);
    repeat (4) tick();
  endtask

  task automatic do_flush();
    if (pend.size() != 0) begin
      drain_fifo();
      push_expected();
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    chk("word_timeout", 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  // FIFO model: data appears the cycle after a pop request, like the real FIFO data_out.
  initial begin : fifo_drv
    logic rd_seen;
    logic toggle;
    toggle     = 1'b0;
    fifo_data  = '0;
    fifo_empty = 1'b1;
    word_ready = 1'b1;
    forever begin
      @(negedge clk);
      rd_seen = enable_rd;
      @(posedge clk);
      #1;
      if (rd_seen) begin
        chk("pop_nonempty", 32'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
      end
      toggle     = ~toggle;
      fifo_empty = (fifo_q.size() == 0) || (empty_mode == 1) || (empty_mode == 2 && toggle);
      word_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    logic        prev_rst;
    logic        prev_empty;
    logic        prev_en;
    logic        prev_valid;
    logic        prev_acc;
    logic        after_acc;
    logic        acc;
    logic [31:0] prev_out;
    logic [2:0]  prev_bytes;
    exp_t        e;
    prev_rst   = 1'b0;
    prev_empty = 1'b1;
    prev_en    = 1'b0;
    prev_valid = 1'b0;
    prev_acc   = 1'b0;
    after_acc  = 1'b0;
    prev_out   = '0;
    prev_bytes = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_rst) begin
          chk("rst_enable_rd", 32'(enable_rd), 0);
          chk("rst_word_valid", 32'(word_valid), 0);
          chk("rst_word_out", word_out, 0);
          chk("rst_word_bytes", 32'(word_bytes), 0);
        end
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
        after_acc  = 1'b0;
        prev_en    = 1'b0;
      end else begin
        if (enable_rd) begin
          en_cnt++;
          chk("rd_after_empty", 32'(prev_empty), 0);
          chk("rd_pulse_width", 32'(prev_en), 0);
          chk("rd_during_out", 32'(word_valid), 0);
        end
        if (after_acc) begin
          chk("accept_clear_out", word_out, 0);
          chk("accept_clear_flags", {29'd0, enable_rd, word_valid, 1'b0} | 32'(word_bytes), 0);
        end
        if (prev_valid && !prev_acc) begin
          chk("hold_valid", 32'(word_valid), 1);
          chk("hold_word", word_out, prev_out);
          chk("hold_bytes", 32'(word_bytes), 32'(prev_bytes));
        end
        if (word_valid) valid_cyc++;
        acc = word_valid && word_ready;
        if (acc) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", word_out, 32'hxxxxxxxx);
          end else begin
            e = exp_q.pop_front();
            chk("word_out", word_out, e.w);
            chk("word_bytes", 32'(word_bytes), 32'(e.n));
          end
        end
        after_acc  = acc;
        prev_acc   = acc;
        prev_valid = word_valid;
        prev_out   = word_out;
        prev_bytes = word_bytes;
        prev_en    = enable_rd;
      end
      prev_rst   = rst;
      prev_empty = fifo_empty;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int e0;
    int v0;
    int t;
    int n;
    rst        = 1'b1;
    flush      = 1'b0;
    ready_mode = 0;
    empty_mode = 0;
    nvec       = 0;
    nerr       = 0;
    en_cnt     = 0;
    valid_cyc  = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    e0 = en_cnt;
    v0 = valid_cyc;
    add_byte(8'h08); add_byte(8'h09); add_byte(8'h0A); add_byte(8'h0C);
    wait_done();
    chk("t1_rd_pulses", 32'(en_cnt - e0), 4);
    chk("t1_valid_cycles", 32'(valid_cyc - v0), 1);

    ready_mode = 1;
    add_byte(8'h08); add_byte(8'h09); add_byte(8'h0A); add_byte(8'h0C);
    for (int i = 0; i < 4; i++) add_byte(8'($urandom));
    t = 0;
    while (!word_valid && t < 200) begin
      tick();
      t++;
    end
    chk("t2_valid_seen", 32'(word_valid), 1);
    repeat (6) tick();
    ready_mode = 0;
    wait_done();

    add_byte(8'h08); add_byte(8'h09);
    do_flush();
    wait_done();

    empty_mode = 1;
    repeat (2) tick();
    e0 = en_cnt;
    v0 = valid_cyc;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (19) tick();
    chk("t4_no_rd", 32'(en_cnt - e0), 0);
    chk("t4_no_valid", 32'(valid_cyc - v0), 0);
    empty_mode = 0;

    add_byte(8'hAA); add_byte(8'hBB);
    drain_fifo();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    pend.delete();
    add_byte(8'h01); add_byte(8'h02); add_byte(8'h03); add_byte(8'h04);
    wait_done();

    empty_mode = 2;
    ready_mode = 2;
    for (int i = 0; i < 8; i++) add_byte(8'($urandom));
    wait_done();

    for (int r = 0; r < 8; r++) begin
      empty_mode = int'($urandom_range(0, 1)) * 2;
      n = int'($urandom_range(1, 11));
      for (int i = 0; i < n; i++) add_byte(8'($urandom));
      do_flush();
      wait_done();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
